// File: rtl/register_bank_ctx.sv
// Multi-entry register bank with one shadow bank. It has two combinational read ports and one write port.
// A handshaked engine copies one entry per cycle between the main bank and the shadow bank.
module register_bank_ctx #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int ZERO_REG = 1
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        wr_en,
  input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] wr_addr,
  input  logic [WIDTH-1:0]                            wr_data,
  input  logic                                        clr,
  input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] rd_addr_a,
  output logic [WIDTH-1:0]                            rd_data_a,
  input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] rd_addr_b,
  output logic [WIDTH-1:0]                            rd_data_b,
  input  logic                                        ctx_req,
  input  logic                                        ctx_op,
  output logic                                        ctx_busy,
  output logic                                        ctx_done
);

  localparam int              AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]     DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW-1:0]   LAST    = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_COPY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic              op_q, op_d;
  logic [WIDTH-1:0]  main_q   [DEPTH];
  logic [WIDTH-1:0]  main_d   [DEPTH];
  logic [WIDTH-1:0]  shadow_q [DEPTH];
  logic [WIDTH-1:0]  shadow_d [DEPTH];
  logic              wr_ok;
  logic              bypass;

  // An address is writable if it lies in range and is not the hard-wired zero entry.
  // Reads return 0 for exactly the addresses that are not writable.
  function automatic logic writable(input logic [AW-1:0] a);
    return ({1'b0, a} < DEPTH_L) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign wr_ok  = wr_en && writable(wr_addr);
  assign bypass = (state_q == S_IDLE) && wr_ok && !clr;

  always_comb begin
    rd_data_a = '0;
    if (writable(rd_addr_a)) begin
      rd_data_a = (bypass && (rd_addr_a == wr_addr)) ? wr_data : main_q[rd_addr_a];
    end
  end

  always_comb begin
    rd_data_b = '0;
    if (writable(rd_addr_b)) begin
      rd_data_b = (bypass && (rd_addr_b == wr_addr)) ? wr_data : main_q[rd_addr_b];
    end
  end

  assign ctx_busy = (state_q == S_COPY);
  assign ctx_done = (state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    op_d    = op_q;
    case (state_q)
      S_IDLE: begin
        if (ctx_req) begin
          state_d = S_COPY;
          idx_d   = '0;
          op_d    = ctx_op;
        end
      end
      S_COPY: begin
        if (idx_q == LAST) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Host write or clear happens only in IDLE. The copy engine owns the bank while it is busy.
  always_comb begin
    main_d   = main_q;
    shadow_d = shadow_q;
    case (state_q)
      S_IDLE: begin
        if (clr) begin
          for (int i = 0; i < DEPTH; i++) main_d[i] = '0;
        end else if (wr_ok) begin
          main_d[wr_addr] = wr_data;
        end
      end
      S_COPY: begin
        if (!op_q) begin
          shadow_d[idx_q] = main_q[idx_q];
        end else if (writable(idx_q)) begin
          main_d[idx_q] = shadow_q[idx_q];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      op_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        main_q[i]   <= '0;
        shadow_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      op_q     <= op_d;
      main_q   <= main_d;
      shadow_q <= shadow_d;
    end
  end

endmodule

// File: tb/tb_register_bank_ctx.sv
// Self-checking bench for register_bank_ctx. It combines table vectors, directed context sequences,
// and random traffic compared against a bank-level model.
module tb_register_bank_ctx;

  logic       clk;
  logic       rst;
  logic       wr_en, clr, ctx_req, ctx_op;
  logic [2:0] wr_addr, rd_addr_a, rd_addr_b;
  logic [7:0] wr_data, rd_data_a, rd_data_b;
  logic       ctx_busy, ctx_done;

  logic       w6_en, c6_clr;
  logic [2:0] w6_addr, r6_a, r6_b;
  logic [7:0] w6_data, q6_a, q6_b;
  logic       b6, d6;

  int n_cmp  = 0;
  int n_fail = 0;

  register_bank_ctx #(.WIDTH(8), .DEPTH(8), .ZERO_REG(1)) u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clr(clr), .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a),
    .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
    .ctx_req(ctx_req), .ctx_op(ctx_op), .ctx_busy(ctx_busy), .ctx_done(ctx_done)
  );

  register_bank_ctx #(.WIDTH(8), .DEPTH(6), .ZERO_REG(1)) u_dut6 (
    .clk(clk), .rst(rst), .wr_en(w6_en), .wr_addr(w6_addr), .wr_data(w6_data),
    .clr(c6_clr), .rd_addr_a(r6_a), .rd_data_a(q6_a),
    .rd_addr_b(r6_b), .rd_data_b(q6_b),
    .ctx_req(1'b0), .ctx_op(1'b0), .ctx_busy(b6), .ctx_done(d6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: bank contents plus a phase counter (0 idle, 1..8 copying entry cnt-1, 9 done).
  logic [7:0] m_main [8];
  logic [7:0] m_shad [8];
  int         m_cnt;
  logic       m_op;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_main[i] = 8'h00;
      m_shad[i] = 8'h00;
    end
    m_cnt = 0;
    m_op  = 1'b0;
  endtask

  task automatic model_edge();
    int k;
    if (m_cnt == 0) begin
      if (clr) begin
        for (int i = 0; i < 8; i++) m_main[i] = 8'h00;
      end else if (wr_en && wr_addr != 3'd0) begin
        m_main[wr_addr] = wr_data;
      end
      if (ctx_req) begin
        m_cnt = 1;
        m_op  = ctx_op;
      end
    end else if (m_cnt <= 8) begin
      k = m_cnt - 1;
      if (!m_op) m_shad[k] = m_main[k];
      else if (k != 0) m_main[k] = m_shad[k];
      m_cnt++;
    end else begin
      m_cnt = 0;
    end
  endtask

  function automatic logic [7:0] exp_rd(input logic [2:0] a);
    if (a == 3'd0) return 8'h00;
    if (m_cnt == 0 && wr_en && !clr && wr_addr == a) return wr_data;
    return m_main[a];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_rd_a"}, rd_data_a, exp_rd(rd_addr_a));
    chk({tag, "_rd_b"}, rd_data_b, exp_rd(rd_addr_b));
    chk({tag, "_busy"}, ctx_busy, (m_cnt >= 1 && m_cnt <= 8));
    chk({tag, "_done"}, ctx_done, (m_cnt == 9));
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst) model_edge();
    @(negedge clk);
  endtask

  task automatic idle_in();
    wr_en = 1'b0; wr_addr = 3'd0; wr_data = 8'h00; clr = 1'b0;
    ctx_req = 1'b0; ctx_op = 1'b0;
  endtask

  task automatic load_entries(input logic [7:0] base);
    for (int i = 1; i < 8; i++) begin
      idle_in();
      wr_en = 1'b1; wr_addr = 3'(i); wr_data = 8'(base + i * 16);
      rd_addr_a = 3'(i); rd_addr_b = 3'(i - 1);
      #1 check_all("load");
      cyc();
    end
    idle_in();
  endtask

  task automatic run_ctx(input logic op, input logic inject, output int nb, output int nd);
    idle_in();
    ctx_req = 1'b1; ctx_op = op;
    #1 check_all("req");
    cyc();
    nb = 0; nd = 0;
    for (int c = 0; c < 14; c++) begin
      idle_in();
      if (inject && c == 2) begin
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 8'hFF; clr = 1'b1;
        ctx_req = 1'b1; ctx_op = ~op;
      end
      rd_addr_a = 3'(c); rd_addr_b = 3'd5;
      #1 check_all("copy");
      if (ctx_busy) nb++;
      if (ctx_done) nd++;
      cyc();
    end
    idle_in();
  endtask

  typedef struct {
    logic       we;
    logic [2:0] wa;
    logic [7:0] wd;
    logic       cl;
    logic [2:0] ra;
    logic [2:0] rb;
    logic [7:0] ea;
    logic [7:0] eb;
  } vec_t;

  vec_t tbl [8];
  int   nb, nd;

  initial begin
    tbl[0] = '{1'b1, 3'd3, 8'hA5, 1'b0, 3'd3, 3'd3, 8'hA5, 8'hA5};
    tbl[1] = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd3, 3'd1, 8'hA5, 8'h00};
    tbl[2] = '{1'b1, 3'd0, 8'h11, 1'b0, 3'd0, 3'd3, 8'h00, 8'hA5};
    tbl[3] = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd3, 8'h00, 8'hA5};
    tbl[4] = '{1'b1, 3'd2, 8'h33, 1'b1, 3'd2, 3'd3, 8'h00, 8'hA5};
    tbl[5] = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd2, 3'd3, 8'h00, 8'h00};
    tbl[6] = '{1'b1, 3'd7, 8'h5A, 1'b0, 3'd7, 3'd6, 8'h5A, 8'h00};
    tbl[7] = '{1'b0, 3'd0, 8'h00, 1'b0, 3'd7, 3'd6, 8'h5A, 8'h00};

    rst = 1'b0;
    idle_in();
    rd_addr_a = 3'd3; rd_addr_b = 3'd7;
    w6_en = 1'b0; w6_addr = 3'd0; w6_data = 8'h00; c6_clr = 1'b0; r6_a = 3'd0; r6_b = 3'd0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rd_a", rd_data_a, 8'h00);
    chk("rst_rd_b", rd_data_b, 8'h00);
    chk("rst_busy", ctx_busy, 1'b0);
    chk("rst_done", ctx_done, 1'b0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      wr_en = tbl[i].we; wr_addr = tbl[i].wa; wr_data = tbl[i].wd; clr = tbl[i].cl;
      rd_addr_a = tbl[i].ra; rd_addr_b = tbl[i].rb;
      #1;
      chk($sformatf("tbl%0d_a", i), rd_data_a, tbl[i].ea);
      chk($sformatf("tbl%0d_b", i), rd_data_b, tbl[i].eb);
      cyc();
    end
    idle_in();

    // Six-entry instance: addresses 6 and 7 lie outside the bank.
    w6_en = 1'b1; w6_addr = 3'd5; w6_data = 8'h66; r6_a = 3'd7; r6_b = 3'd5;
    #1 chk("d6_oor_a", q6_a, 8'h00);
    chk("d6_byp_b", q6_b, 8'h66);
    cyc();
    w6_addr = 3'd6; w6_data = 8'h77; r6_a = 3'd6; r6_b = 3'd5;
    #1 chk("d6_wr6_byp", q6_a, 8'h00);
    chk("d6_keep5", q6_b, 8'h66);
    cyc();
    w6_en = 1'b0;
    #1 chk("d6_rd6", q6_a, 8'h00);
    cyc();
    w6_en = 1'b1; w6_addr = 3'd2; w6_data = 8'h33; c6_clr = 1'b1; r6_a = 3'd2;
    #1 chk("d6_clr_nobyp", q6_a, 8'h00);
    cyc();
    w6_en = 1'b0; c6_clr = 1'b0;
    #1 chk("d6_clr_a2", q6_a, 8'h00);
    chk("d6_clr_a5", q6_b, 8'h00);

    // Save the bank, with blocked traffic during the copy. Then clear and restore.
    load_entries(8'h00);
    run_ctx(1'b0, 1'b1, nb, nd);
    chk("save_busy_cycles", nb, 8);
    chk("save_done_pulses", nd, 1);
    clr = 1'b1;
    #1 check_all("clr");
    cyc();
    idle_in();
    for (int a = 0; a < 8; a++) begin
      rd_addr_a = 3'(a); rd_addr_b = 3'(7 - a);
      #1 chk($sformatf("cleared_%0d", a), rd_data_a, 8'h00);
      cyc();
    end
    run_ctx(1'b1, 1'b0, nb, nd);
    chk("rest_busy_cycles", nb, 8);
    chk("rest_done_pulses", nd, 1);
    for (int a = 0; a < 8; a++) begin
      rd_addr_a = 3'(a); rd_addr_b = 3'd5;
      #1 chk($sformatf("restored_%0d", a), rd_data_a, 8'(a * 16));
      chk("entry5_kept", rd_data_b, 8'h50);
      cyc();
    end

    // Reset lands in the fourth copy cycle.
    ctx_req = 1'b1; ctx_op = 1'b0;
    #1 check_all("req2");
    cyc();
    idle_in();
    for (int c = 0; c < 3; c++) begin
      #1 check_all("pre_rst");
      cyc();
    end
    rd_addr_a = 3'd3; rd_addr_b = 3'd7;
    #3 rst = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_busy", ctx_busy, 1'b0);
    chk("mid_rst_done", ctx_done, 1'b0);
    chk("mid_rst_rd_a", rd_data_a, 8'h00);
    chk("mid_rst_rd_b", rd_data_b, 8'h00);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    nd = 0;
    for (int c = 0; c < 12; c++) begin
      #1 check_all("post_rst");
      if (ctx_done) nd++;
      cyc();
    end
    chk("no_done_after_abort", nd, 0);
    load_entries(8'h0E);
    run_ctx(1'b1, 1'b0, nb, nd);
    chk("rst_rest_done_pulses", nd, 1);
    for (int a = 0; a < 8; a++) begin
      rd_addr_a = 3'(a);
      #1 chk($sformatf("shadow_zero_%0d", a), rd_data_a, 8'h00);
      cyc();
    end

    // Random traffic checked every cycle against the model.
    for (int c = 0; c < 400; c++) begin
      wr_en     = 1'($urandom_range(0, 1));
      wr_addr   = 3'($urandom_range(0, 7));
      wr_data   = 8'($urandom);
      clr       = ($urandom_range(0, 15) == 0);
      ctx_req   = ($urandom_range(0, 15) == 0);
      ctx_op    = 1'($urandom_range(0, 1));
      rd_addr_a = 3'($urandom_range(0, 7));
      rd_addr_b = ($urandom_range(0, 3) == 0) ? wr_addr : 3'($urandom_range(0, 7));
      #1 check_all("rnd");
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/register_bank_ctx.md
Name: register_bank_ctx

Overview:
- Parametrised multi-entry register bank with a single shadow bank for context save/restore.
- Generalises the team's single load-enable registers to DEPTH entries of WIDTH bits.
- Two combinational read ports, one synchronous write port, synchronous clear, and a handshaked bulk save/restore engine that copies one entry per cycle.
- Serves as the datapath register file of the multicycle core. The controller FSM drives it directly.

Parameters:
- WIDTH, 8, data width of each entry; must be at least 1.
- DEPTH, 8, number of entries; must be at least 2. Address width AW = clog2(DEPTH), as a localparam.
- ZERO_REG, 1, when 1, entry 0 always reads 0 and ignores writes, clear and restore.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-low.
- wr_en  in  1  write strobe.
- wr_addr  in  AW  write address.
- wr_data  in  WIDTH  write data.
- clr  in  1  synchronous clear of the main bank.
- rd_addr_a  in  AW  read address, port A.
- rd_data_a  out  WIDTH  read data, port A.
- rd_addr_b  in  AW  read address, port B.
- rd_data_b  out  WIDTH  read data, port B.
- ctx_req  in  1  start a context operation; sampled in IDLE only.
- ctx_op  in  1  0 = save (main to shadow), 1 = restore (shadow to main); sampled with ctx_req.
- ctx_busy  out  1  copy in progress.
- ctx_done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (rst low, asynchronous):
  - All main and shadow entries go to 0.
  - FSM goes to IDLE, copy index to 0, latched op to 0.
  - ctx_busy = 0, ctx_done = 0.
  - Reset takes effect immediately, including mid-copy, and aborts the copy with no done pulse.
- FSM states: IDLE, COPY, DONE.
  - IDLE -> COPY at an edge with ctx_req = 1. Latch ctx_op and set index = 0.
  - COPY: at each edge, copy entry[index] in the latched direction.
    - If index == DEPTH-1, go to DONE; otherwise index increments.
  - DONE -> IDLE unconditionally after one cycle.
- Timing of a context operation:
  - ctx_busy = 1 exactly while in COPY, i.e. DEPTH cycles.
  - ctx_done = 1 exactly while in DONE, i.e. 1 cycle. Both outputs decode from the registered state.
  - ctx_req is ignored in COPY and DONE; it is not queued.
- Writes:
  - At the rising edge when wr_en = 1, state == IDLE and clr = 0: main[wr_addr] <= wr_data.
  - Ignored when wr_addr >= DEPTH.
  - Ignored when ZERO_REG = 1 and wr_addr == 0.
  - Writes during COPY or DONE are dropped silently; the controller must hold them off using ctx_busy.
- Clear:
  - clr = 1 in IDLE zeroes every main entry at the edge. The shadow bank is untouched.
  - clr overrides wr_en in the same cycle.
  - clr in COPY or DONE is ignored.
- Simultaneous clr or wr_en with ctx_req in IDLE:
  - The write or clear is applied at that edge and the FSM enters COPY.
  - A save therefore captures post-write contents; the first copy occurs at the next edge.
- Reads (combinational):
  - rd_data = main[rd_addr].
  - Returns 0 when rd_addr >= DEPTH.
  - Returns 0 for address 0 when ZERO_REG = 1.
  - Write bypass: in IDLE with wr_en = 1, clr = 0 and rd_addr == wr_addr (a valid, writable address), rd_data = wr_data.
  - During clr in IDLE, reads still return the old contents; there is no clear bypass.
- Reads during restore see partially updated contents: entries with index < current index are already restored. The controller must not rely on them until ctx_done.
- Restore never writes entry 0 when ZERO_REG = 1.

Test Plan:
- Reset: hold rst low mid-run -> all reads 0, ctx_busy = 0 and ctx_done = 0 immediately; release -> bank idle.
- Write/read with bypass: write 0xA5 to addr 3 with rd_addr_a = 3 in the same cycle -> rd_data_a = 0xA5 before the edge and 0xA5 after. Write 0x11 to addr 0 with ZERO_REG = 1 -> reads 0.
- Save/modify/restore, DEPTH = 8:
  - Load entries 1..7 with 0x10..0x70 and pulse ctx_req with ctx_op = 0 -> ctx_busy high for exactly 8 cycles, then ctx_done high for 1 cycle.
  - Issue clr -> all entries read 0.
  - Restore with ctx_op = 1 -> after ctx_done, entries read 0x10..0x70.
- Blocked traffic: wr_en to addr 5 with 0xFF, clr, and a second ctx_req, all during COPY -> no effect; entry 5 keeps its value and only one ctx_done pulse occurs.
- Clear priority: clr = 1 and wr_en = 1 (addr 2, 0x33) in the same cycle -> addr 2 reads 0. Out-of-range rd_addr with DEPTH = 6 and addr 7 -> read returns 0.
- Reset mid-copy: assert rst at the 4th COPY cycle -> no ctx_done; shadow and main are all 0; a new ctx_req then works normally.
